leaf_rx_demux: RTL and testbench

- Ingress stage of a PR leaf page. Sits between the BFT leaf port and the user-side stream converters.
- Decodes incoming BFT packets and sorts their payloads into one buffered 32-bit stream per user input port.
- Returns freespace credit packets to the controller leaf as the user drains each buffer.
- Feeds width converters or user kernel inputs directly.

---
 rtl/leaf_rx_demux.sv | 254 +++++++++++++++++++++++++
 tb/tb_leaf_rx_demux.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/leaf_rx_demux.sv
// BFT leaf ingress: sorts packet payloads into per-port FWFT buffers
// and returns freespace credit packets to the controller leaf.
module leaf_rx_demux #(
  parameter int PACKET_BITS           = 49,
  parameter int PAYLOAD_BITS          = 32,
  parameter int NUM_LEAF_BITS         = 5,
  parameter int NUM_PORT_BITS         = 4,
  parameter int NUM_ADDR_BITS         = 7,
  parameter int NUM_IN_PORTS          = 2,
  parameter int NUM_BRAM_ADDR_BITS    = 7,
  parameter int FREESPACE_UPDATE_SIZE = 64,
  parameter int SELF_LEAF             = 6,
  parameter int CTRL_LEAF             = 0
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   ap_start,
  input  logic [PACKET_BITS-1:0]                 din_leaf_bft2interface,
  output logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]   dout_leaf_interface2user,
  output logic [NUM_IN_PORTS-1:0]                vld_interface2user,
  input  logic [NUM_IN_PORTS-1:0]                ack_user2interface,
  output logic [PACKET_BITS-1:0]                 credit_pkt,
  output logic                                   credit_vld,
  input  logic                                   credit_rdy,
  output logic                                   ovf_err,
  output logic [15:0]                            drop_cnt
);

  localparam int PL = PAYLOAD_BITS;
  localparam int AB = NUM_ADDR_BITS;
  localparam int PB = NUM_PORT_BITS;
  localparam int LB = NUM_LEAF_BITS;
  localparam int N  = NUM_IN_PORTS;
  localparam int AW = NUM_BRAM_ADDR_BITS;
  localparam int D  = 2 ** AW;
  localparam int CW = $clog2(FREESPACE_UPDATE_SIZE + 1);
  localparam int GW = $clog2(N + 1);

  localparam logic [PB-1:0]   PORT_LO  = PB'(2);
  localparam logic [PB-1:0]   PORT_HI  = PB'(N + 1);
  localparam logic [LB-1:0]   MY_LEAF  = LB'(SELF_LEAF);
  localparam logic [CW-1:0]   RD_LAST  = CW'(FREESPACE_UPDATE_SIZE - 1);
  localparam logic [AW+1:0]   FULL_LVL = (AW + 2)'(D);

  typedef enum logic {IDLE, SEND} state_e;

  logic          pkt_v;
  logic [LB-1:0] pkt_leaf;
  logic [PB-1:0] pkt_port;
  logic [PL-1:0] pkt_data;
  logic          pkt_hit;
  logic          unused_addr;

  assign pkt_v       = din_leaf_bft2interface[PACKET_BITS-1];
  assign pkt_leaf    = din_leaf_bft2interface[PL+AB+PB +: LB];
  assign pkt_port    = din_leaf_bft2interface[PL+AB +: PB];
  assign pkt_data    = din_leaf_bft2interface[PL-1:0];
  assign unused_addr = ^din_leaf_bft2interface[PL +: AB];

  assign pkt_hit = pkt_v && ap_start && (pkt_leaf == MY_LEAF)
                && (pkt_port >= PORT_LO) && (pkt_port <= PORT_HI);

  logic [PL-1:0]   mem_q    [N][D];
  logic [AW-1:0]   wr_ptr_q [N];
  logic [AW-1:0]   wr_ptr_d [N];
  logic [AW-1:0]   rd_ptr_q [N];
  logic [AW-1:0]   rd_ptr_d [N];
  logic [AW:0]     mcnt_q   [N];
  logic [AW:0]     mcnt_d   [N];
  logic [PL-1:0]   odat_q   [N];
  logic [PL-1:0]   odat_d   [N];
  logic [N-1:0]    ovld_q, ovld_d;
  logic [CW-1:0]   rcnt_q   [N];
  logic [CW-1:0]   rcnt_d   [N];
  logic [7:0]      pend_q   [N];
  logic [7:0]      pend_d   [N];
  logic [N-1:0]    pop, push, full, push_ok;
  logic [N-1:0]    mem_we, mem_rd, inc, dec;
  logic [AW+1:0]   tot      [N];
  logic            ovf_q, ovf_d;
  logic [15:0]     drop_q, drop_d;
  logic            bump_drop;

  state_e               state_q, state_d;
  logic [GW-1:0]        last_q, last_d;
  logic [GW-1:0]        gnt;
  logic                 found;
  logic                 load;
  logic [PACKET_BITS-1:0] cpkt_q, cpkt_d;

  // Output register is refilled from memory first; an empty FIFO
  // bypasses the incoming word straight into it.
  always_comb begin
    ovf_d     = ovf_q;
    drop_d    = drop_q;
    bump_drop = pkt_v && !pkt_hit;
    ovld_d    = ovld_q;
    for (int k = 0; k < N; k++) begin
      wr_ptr_d[k] = wr_ptr_q[k];
      rd_ptr_d[k] = rd_ptr_q[k];
      mcnt_d[k]   = mcnt_q[k];
      odat_d[k]   = odat_q[k];
      mem_we[k]   = 1'b0;
      mem_rd[k]   = 1'b0;
      pop[k]      = ovld_q[k] && ack_user2interface[k];
      push[k]     = pkt_hit && (pkt_port == PB'(k + 2));
      tot[k]      = {1'b0, mcnt_q[k]} + (AW + 2)'(ovld_q[k]);
      full[k]     = (tot[k] == FULL_LVL);
      push_ok[k]  = push[k] && (!full[k] || pop[k]);
      if (push[k] && full[k] && !pop[k]) begin
        ovf_d     = 1'b1;
        bump_drop = 1'b1;
      end
      if (!ovld_q[k] || pop[k]) begin
        if (mcnt_q[k] != '0) begin
          ovld_d[k] = 1'b1;
          odat_d[k] = mem_q[k][rd_ptr_q[k]];
          mem_rd[k] = 1'b1;
          mem_we[k] = push_ok[k];
        end else if (push_ok[k]) begin
          ovld_d[k] = 1'b1;
          odat_d[k] = pkt_data;
        end else begin
          ovld_d[k] = 1'b0;
        end
      end else begin
        mem_we[k] = push_ok[k];
      end
      if (mem_we[k]) wr_ptr_d[k] = wr_ptr_q[k] + AW'(1);
      if (mem_rd[k]) rd_ptr_d[k] = rd_ptr_q[k] + AW'(1);
      mcnt_d[k] = mcnt_q[k] + (AW + 1)'(mem_we[k])
                - (AW + 1)'(mem_rd[k]);
    end
    if (bump_drop && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;
  end

  always_comb begin
    for (int k = 0; k < N; k++) begin
      inc[k]    = 1'b0;
      rcnt_d[k] = rcnt_q[k];
      if (pop[k]) begin
        if (rcnt_q[k] == RD_LAST) begin
          rcnt_d[k] = '0;
          inc[k]    = 1'b1;
        end else begin
          rcnt_d[k] = rcnt_q[k] + CW'(1);
        end
      end
    end
  end

  // Round-robin: ports above the last grant first, then wrap around.
  always_comb begin
    found = 1'b0;
    gnt   = '0;
    for (int k = 0; k < N; k++) begin
      if (!found && (pend_q[k] != '0) && (GW'(k + 1) > last_q)) begin
        found = 1'b1;
        gnt   = GW'(k + 1);
      end
    end
    for (int k = 0; k < N; k++) begin
      if (!found && (pend_q[k] != '0)) begin
        found = 1'b1;
        gnt   = GW'(k + 1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cpkt_d  = cpkt_q;
    load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          load    = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        if (credit_rdy) begin
          if (found) load = 1'b1;
          else state_d = IDLE;
        end
      end
    endcase
    if (load) begin
      last_d = gnt;
      cpkt_d = {1'b1, LB'(CTRL_LEAF), PB'(0), AB'(gnt),
                PL'(FREESPACE_UPDATE_SIZE)};
    end
    for (int k = 0; k < N; k++) begin
      dec[k]    = load && (gnt == GW'(k + 1));
      pend_d[k] = pend_q[k];
      if (inc[k] && !dec[k] && (pend_q[k] != 8'hFF))
        pend_d[k] = pend_q[k] + 8'd1;
      else if (dec[k] && !inc[k])
        pend_d[k] = pend_q[k] - 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < N; k++) begin
      if (mem_we[k]) mem_q[k][wr_ptr_q[k]] <= pkt_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < N; k++) begin
        wr_ptr_q[k] <= '0;
        rd_ptr_q[k] <= '0;
        mcnt_q[k]   <= '0;
        odat_q[k]   <= '0;
        rcnt_q[k]   <= '0;
        pend_q[k]   <= '0;
      end
      ovld_q  <= '0;
      ovf_q   <= 1'b0;
      drop_q  <= '0;
      state_q <= IDLE;
      last_q  <= '0;
      cpkt_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mcnt_q   <= mcnt_d;
      odat_q   <= odat_d;
      rcnt_q   <= rcnt_d;
      pend_q   <= pend_d;
      ovld_q   <= ovld_d;
      ovf_q    <= ovf_d;
      drop_q   <= drop_d;
      state_q  <= state_d;
      last_q   <= last_d;
      cpkt_q   <= cpkt_d;
    end
  end

  always_comb begin
    for (int k = 0; k < N; k++) begin
      dout_leaf_interface2user[k*PL +: PL] = odat_q[k];
    end
  end

  assign vld_interface2user = ovld_q;
  assign credit_pkt         = cpkt_q;
  assign credit_vld         = (state_q == SEND);
  assign ovf_err            = ovf_q;
  assign drop_cnt           = drop_q;

endmodule

// File: tb/tb_leaf_rx_demux.sv
// Scoreboard bench for leaf_rx_demux: routing, drops, credits,
// overflow and mid-stream reset.
module tb_leaf_rx_demux;

  localparam int N   = 2;
  localparam int D   = 128;
  localparam int FUS = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic          ap_start;
  logic [48:0]   din;
  logic [63:0]   dout;
  logic [1:0]    vld;
  logic [1:0]    ack;
  logic [48:0]   cpkt;
  logic          cvld;
  logic          crdy;
  logic          ovf;
  logic [15:0]   dcnt;

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] exp_q [N][$];
  logic [48:0] cexp_q[$];
  int rd_m [N];
  int drop_m;
  bit ovf_m;
  int cyc_n = 0;
  int pop_cyc, cred_cyc, cred_prev;
  int credit_seen, cvld_cycles;

  always #5 clk = ~clk;

  leaf_rx_demux dut (
    .clk                      (clk),
    .reset                    (reset),
    .ap_start                 (ap_start),
    .din_leaf_bft2interface   (din),
    .dout_leaf_interface2user (dout),
    .vld_interface2user       (vld),
    .ack_user2interface       (ack),
    .credit_pkt               (cpkt),
    .credit_vld               (cvld),
    .credit_rdy               (crdy),
    .ovf_err                  (ovf),
    .drop_cnt                 (dcnt)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [48:0] mk_credit(input int k);
    return {1'b1, 5'd0, 4'd0, 7'(k), 32'(FUS)};
  endfunction

  always @(negedge clk) begin
    #2;
    cyc_n++;
    if (!reset) begin
      for (int k = 0; k < N; k++) begin
        if (vld[k] && ack[k]) begin
          pop_cyc = cyc_n;
          if (exp_q[k].size() == 0) begin
            chk($sformatf("p%0d_extra_word", k + 1), exp_q[k].size(), 1);
          end else begin
            chk($sformatf("p%0d_data", k + 1), dout[k*32 +: 32],
                exp_q[k].pop_front());
          end
          rd_m[k]++;
          if (rd_m[k] == FUS) begin
            rd_m[k] = 0;
            cexp_q.push_back(mk_credit(k + 1));
          end
        end
      end
      if (cvld) cvld_cycles++;
      if (cvld && crdy) begin
        credit_seen++;
        cred_prev = cred_cyc;
        cred_cyc  = cyc_n;
        if (cexp_q.size() == 0)
          chk("credit_extra", cexp_q.size(), 1);
        else
          chk("credit_pkt", cpkt, cexp_q.pop_front());
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    din   = '0;
    ack   = '0;
    crdy  = 1'b1;
    for (int k = 0; k < N; k++) begin
      exp_q[k].delete();
      rd_m[k] = 0;
    end
    cexp_q.delete();
    drop_m      = 0;
    ovf_m       = 1'b0;
    credit_seen = 0;
    cvld_cycles = 0;
    pop_cyc     = 0;
    cred_cyc    = 0;
    cred_prev   = 0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic inject(input bit v, input int leaf, input int port,
                        input logic [31:0] pl);
    din = {v, 5'(leaf), 4'(port), 7'(0), pl};
    if (v) begin
      if (ap_start && leaf == 6 && port >= 2 && port <= N + 1) begin
        if (exp_q[port-2].size() < D) begin
          exp_q[port-2].push_back(pl);
        end else begin
          drop_m++;
          ovf_m = 1'b1;
        end
      end else begin
        drop_m++;
      end
    end
    @(negedge clk);
    din = '0;
  endtask

  task automatic drain();
    int t;
    t   = 0;
    ack = 2'b11;
    while ((exp_q[0].size() + exp_q[1].size()) != 0 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    chk("drain_left", exp_q[0].size() + exp_q[1].size(), 0);
    cyc(4);
    chk("vld_idle", vld, 2'b00);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [48:0] c1;
    reset    = 1'b1;
    ap_start = 1'b0;
    din      = '0;
    ack      = '0;
    crdy     = 1'b1;
    cyc(2);

    do_reset();
    chk("rst_vld", vld, 0);
    chk("rst_dout", dout, 0);
    chk("rst_cvld", cvld, 0);
    chk("rst_cpkt", cpkt, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_drop", dcnt, 0);

    ap_start = 1'b1;
    inject(1, 6, 2, 32'hDEADBEEF);
    chk("single_vld", vld, 2'b01);
    chk("single_dout", dout[31:0], 32'hDEADBEEF);
    ack = 2'b01;
    cyc(1);
    chk("single_vld_drop", vld, 2'b00);
    chk("single_left", exp_q[0].size(), 0);
    ack = 2'b00;

    do_reset();
    inject(1, 6, 3, 32'h11);
    inject(1, 6, 0, 32'h22);
    inject(1, 5, 2, 32'h33);
    inject(0, 6, 2, 32'h55);
    inject(1, 6, 4, 32'h66);
    chk("route_vld", vld, 2'b10);
    chk("route_dout", dout[63:32], 32'h11);
    ap_start = 1'b0;
    inject(1, 6, 2, 32'h44);
    ap_start = 1'b1;
    chk("drop_cnt", dcnt, 16'(drop_m));
    drain();

    do_reset();
    for (int i = 0; i < FUS; i++) inject(1, 6, 2, 32'(100 + i));
    chk("cr_none_yet", cvld, 0);
    drain();
    chk("cr_count", credit_seen, 1);
    chk("cr_hi_cycles", cvld_cycles, 1);
    chk("cr_latency", cred_cyc - pop_cyc, 2);
    for (int i = 0; i < FUS - 1; i++) inject(1, 6, 2, 32'(200 + i));
    drain();
    chk("cr_after_63", credit_seen, 1);
    chk("cr_q_left", cexp_q.size(), 0);

    do_reset();
    crdy = 1'b0;
    for (int i = 0; i < FUS; i++) begin
      inject(1, 6, 2, 32'(300 + i));
      inject(1, 6, 3, 32'(400 + i));
    end
    drain();
    c1 = mk_credit(1);
    chk("bp_cvld", cvld, 1);
    chk("bp_addr1", cpkt, c1);
    cyc(5);
    chk("bp_cvld_held", cvld, 1);
    chk("bp_addr1_held", cpkt, c1);
    crdy = 1'b1;
    cyc(5);
    chk("rr_count", credit_seen, 2);
    chk("rr_gap", cred_cyc - cred_prev, 1);
    chk("rr_q_left", cexp_q.size(), 0);
    chk("rr_cvld_off", cvld, 0);

    do_reset();
    for (int i = 0; i <= D; i++) inject(1, 6, 2, 32'(1000 + i));
    chk("ovf_flag", ovf, ovf_m);
    chk("ovf_drop", dcnt, 16'(drop_m));
    chk("ovf_stored", exp_q[0].size(), D);
    drain();
    chk("ovf_sticky", ovf, 1);

    ack = 2'b00;
    for (int i = 0; i < 10; i++) inject(1, 6, 3, 32'(2000 + i));
    chk("mid_vld", vld, 2'b10);
    do_reset();
    chk("mid_rst_vld", vld, 0);
    chk("mid_rst_ovf", ovf, 0);
    chk("mid_rst_drop", dcnt, 0);
    chk("mid_rst_cvld", cvld, 0);
    inject(1, 6, 3, 32'hCAFE0001);
    chk("post_rst_vld", vld, 2'b10);
    chk("post_rst_dout", dout[63:32], 32'hCAFE0001);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
